cc_banks_param: RTL and testbench

Parametrised banked single-port RAM for the cache data array, generalising the fixed four-bank 8K×64 arrangement. The address MSBs select one of NBANKS single-port SRAM macros. Only the selected bank is enabled per access. Writes are byte-masked. Read data returns through a valid-qualified pipeline. Each bank has a light-sleep controller that parks the bank after a run of idle cycles and wakes it on demand, stalling the requester through a ready handshake.

---
 rtl/cc_banks_param.sv | 231 +++++++++++++++++++++++
 tb/tb_cc_banks_param.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_banks_param.sv
// ============================================================================
// cc_banks_param
//   Banked single-port RAM for the cache data array. The address MSBs pick
//   one of NBANKS single-port macros; only that bank is enabled per access.
//   Byte-masked writes, valid-qualified read return, and a per-bank
//   light-sleep controller that parks idle banks and stalls requests to a
//   waking bank through RW0_ready.
//   Optional build macro: CC_BANKS_OUT_REG_EN (adds an output register
//   stage after the bank mux, read latency 1 -> 2).
//   Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef CC_MEM_CTRL_SASRL_1P_T
`define CC_MEM_CTRL_SASRL_1P_T
// Macro timing/margin trims, forwarded untouched to every bank macro.
typedef struct packed {
  logic [1:0] rtsel;
  logic [1:0] wtsel;
  logic [1:0] ptsel;
  logic       mcen;
  logic       rmce;
} mem_ctrl_sasrl_1p_t;
`endif

module cc_banks_param #(
  parameter int NBANKS      = 4,
  parameter int BANK_DEPTH  = 2048,
  parameter int WIDTH       = 64,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  localparam int AW = $clog2(NBANKS * BANK_DEPTH),
  localparam int BW = $clog2(NBANKS)
) (
  input  logic                   RW0_clk,
  input  logic                   RW0_rst_n,
  input  logic                   RW0_en,
  output logic                   RW0_ready,
  input  logic                   RW0_wmode,
  input  logic [AW-1:0]          RW0_addr,
  input  logic [WIDTH-1:0]       RW0_wdata,
  input  logic [WIDTH/8-1:0]     RW0_wmask,
  output logic                   RW0_rvalid,
  output logic [WIDTH-1:0]       RW0_rdata,
  output logic [NBANKS-1:0]      bank_sleep,
  input  mem_ctrl_sasrl_1p_t     mem_ctrl_sasrl
);

  localparam int IW = AW - BW;
  localparam int MW = WIDTH / 8;

  // Per-bank power FSM encoding
  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_SLEEP  = 2'd1;
  localparam logic [1:0] ST_WAKE   = 2'd2;

  // Counter terminal values: the idle counter hits IDLE_CYCLES on the
  // cycle it is already at IDLE_CYCLES-1 with no access.
  localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
  localparam logic [7:0] IDLE_SAT  = 8'hFF;
  localparam logic [2:0] WAKE_LAST = 3'(WAKE_CYCLES - 1);

  logic [BW-1:0]     req_bank;
  logic [IW-1:0]     req_idx;
  logic [NBANKS-1:0] bank_hit;
  logic [NBANKS-1:0] bank_active;
  logic [NBANKS-1:0] bank_me;
  logic [NBANKS-1:0] bank_we;
  logic              accept;
  logic              rd_fire;
  logic [WIDTH-1:0]  bank_q [NBANKS];

  // Read pipeline state
  logic              rd_pend;
  logic [BW-1:0]     rd_bank;
  logic [WIDTH-1:0]  rd_mux;

  // The behavioural macro model has no timing trims to apply.
  logic              unused_sasrl;
  assign unused_sasrl = ^mem_ctrl_sasrl;

  assign req_bank = RW0_addr[AW-1:IW];
  assign req_idx  = RW0_addr[IW-1:0];

  // Request decode: ready follows the addressed bank only, so a waking bank
  // never blocks requests to the others.
  always_comb begin
    RW0_ready = bank_active[req_bank];
    accept    = RW0_en && RW0_ready;
    rd_fire   = accept && !RW0_wmode;
    bank_me   = bank_hit & {NBANKS{RW0_ready}};
    bank_we   = bank_me & {NBANKS{RW0_wmode}};
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [7:0]       idle_cnt;
    logic [2:0]       wake_cnt;
    logic             active_o;
    logic             sleep_o;
    logic [WIDTH-1:0] mem [BANK_DEPTH];
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] merged;

    assign bank_hit[b] = RW0_en && (req_bank == BW'(b));

    // Power FSM state register
    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
      if (!RW0_rst_n) begin
        state <= ST_ACTIVE;
      end else begin
        state <= state_nxt;
      end
    end

    // Power FSM next state; an access in the terminal idle cycle wins
    always_comb begin
      state_nxt = state;
      case (state)
        ST_ACTIVE: if (!bank_me[b] && (idle_cnt == IDLE_LAST)) state_nxt = ST_SLEEP;
        ST_SLEEP:  if (bank_hit[b]) state_nxt = ST_WAKE;
        ST_WAKE:   if (wake_cnt == WAKE_LAST) state_nxt = ST_ACTIVE;
        default:   state_nxt = ST_ACTIVE;
      endcase
    end

    // Power FSM outputs; LS drops in the same cycle a request hits the bank
    always_comb begin
      active_o = (state == ST_ACTIVE);
      sleep_o  = (state == ST_SLEEP) && !bank_hit[b];
    end

    assign bank_active[b] = active_o;
    assign bank_sleep[b]  = sleep_o;

    // Idle counter: clears on access or outside ACTIVE, saturates otherwise
    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
      if (!RW0_rst_n) begin
        idle_cnt <= 8'd0;
      end else if ((state != ST_ACTIVE) || bank_me[b]) begin
        idle_cnt <= 8'd0;
      end else if (idle_cnt != IDLE_SAT) begin
        idle_cnt <= idle_cnt + 8'd1;
      end
    end

    // Wake counter: counts the cycles spent in WAKE
    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
      if (!RW0_rst_n) begin
        wake_cnt <= 3'd0;
      end else if ((state == ST_WAKE) && (wake_cnt != WAKE_LAST)) begin
        wake_cnt <= wake_cnt + 3'd1;
      end else begin
        wake_cnt <= 3'd0;
      end
    end

    // Byte merge of write data over the stored word
    always_comb begin
      merged = mem[req_idx];
      for (int i = 0; i < MW; i++) begin
        if (RW0_wmask[i]) merged[8*i +: 8] = RW0_wdata[8*i +: 8];
      end
    end

    // Single-port write-first macro model (array carries no reset)
    always_ff @(posedge RW0_clk) begin
      if (bank_me[b]) begin
        if (bank_we[b]) begin
          mem[req_idx] <= merged;
          q            <= merged;
        end else begin
          q <= mem[req_idx];
        end
      end
    end

    assign bank_q[b] = q;
  end : g_bank

  // Read pipeline: capture bank index and read flag at acceptance so a later
  // access cannot redirect the returning data.
  always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
    if (!RW0_rst_n) begin
      rd_pend <= 1'b0;
      rd_bank <= '0;
    end else begin
      rd_pend <= rd_fire;
      if (rd_fire) rd_bank <= req_bank;
    end
  end

  assign rd_mux = bank_q[rd_bank];

`ifdef CC_BANKS_OUT_REG_EN
  logic             rvalid_q;
  logic [WIDTH-1:0] rdata_q;

  // Output stage: flop valid and data after the bank mux
  always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
    if (!RW0_rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rd_pend;
      if (rd_pend) rdata_q <= rd_mux;
    end
  end

  assign RW0_rvalid = rvalid_q;
  assign RW0_rdata  = rdata_q;
`else
  logic [WIDTH-1:0] rdata_q;

  // Hold copy of the last returned word for cycles without rvalid
  always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
    if (!RW0_rst_n) begin
      rdata_q <= '0;
    end else if (rd_pend) begin
      rdata_q <= rd_mux;
    end
  end

  assign RW0_rvalid = rd_pend;
  assign RW0_rdata  = rd_pend ? rd_mux : rdata_q;
`endif

endmodule : cc_banks_param

`default_nettype wire

// File: tb/tb_cc_banks_param.sv
// ============================================================================
// tb_cc_banks_param
//   Directed bench for cc_banks_param with the default configuration
//   (4 banks x 2048 x 64, idle 16, wake 2).
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cc_banks_param;

`ifdef CC_BANKS_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [63:0] D2 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] V1 = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [63:0] V3 = 64'h5A5A_1234_8765_C3C3;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        ready;
  logic        wmode;
  logic [12:0] addr;
  logic [63:0] wdata;
  logic [7:0]  wmask;
  logic        rvalid;
  logic [63:0] rdata;
  logic [3:0]  bank_sleep;

  int total;
  int bad;

  cc_banks_param dut (
    .RW0_clk        (clk),
    .RW0_rst_n      (rst_n),
    .RW0_en         (en),
    .RW0_ready      (ready),
    .RW0_wmode      (wmode),
    .RW0_addr       (addr),
    .RW0_wdata      (wdata),
    .RW0_wmask      (wmask),
    .RW0_rvalid     (rvalid),
    .RW0_rdata      (rdata),
    .bank_sleep     (bank_sleep),
    .mem_ctrl_sasrl ('0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request and hold it until accepted (bounded); returns 1ns after
  // the accepting edge with en dropped.
  task automatic access(input logic wr, input logic [12:0] a, input logic [63:0] d,
                        input logic [7:0] m, input string tag);
    logic got;
    got   = 1'b0;
    en    = 1'b1;
    wmode = wr;
    addr  = a;
    wdata = d;
    wmask = m;
    for (int n = 0; n < 16 && !got; n++) begin
      #1;
      got = ready;
      tick();
    end
    en = 1'b0;
    chk({tag, "_accept"}, 64'(got), 64'd1);
  endtask

  task automatic read_check(input logic [12:0] a, input logic [63:0] exp, input string tag);
    access(1'b0, a, 64'd0, 8'd0, tag);
    repeat (LAT - 1) tick();
    chk({tag, "_rvalid"}, 64'(rvalid), 64'd1);
    chk({tag, "_rdata"}, rdata, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ord [4];
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    wmode = 1'b0;
    addr  = 13'd0;
    wdata = 64'd0;
    wmask = 8'd0;

    // Reset state
    tick();
    tick();
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_sleep", 64'(bank_sleep), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // One write per bank at word 5, then read each back
    for (int b = 0; b < 4; b++)
      access(1'b1, {2'(b), 11'd5}, 64'hA5A5_0000_0000_0000 | 64'(b), 8'hFF, "wr_bank");
    for (int b = 0; b < 4; b++)
      read_check({2'(b), 11'd5}, 64'hA5A5_0000_0000_0000 | 64'(b), "rd_bank");

    // Back-to-back reads 0,3,1,2: one accepted per cycle, returned in order
    ord[0] = 2'd0;
    ord[1] = 2'd3;
    ord[2] = 2'd1;
    ord[3] = 2'd2;
    for (int i = 0; i < 4 + LAT; i++) begin
      if (i < 4) begin
        en    = 1'b1;
        wmode = 1'b0;
        addr  = {ord[i], 11'd5};
      end else begin
        en = 1'b0;
      end
      #1;
      if (i < 4) chk("b2b_ready", 64'(ready), 64'd1);
      if (i >= LAT) begin
        chk("b2b_rvalid", 64'(rvalid), 64'd1);
        chk("b2b_rdata", rdata, 64'hA5A5_0000_0000_0000 | 64'(ord[i-LAT]));
      end
      tick();
    end
    chk("b2b_done_rvalid", 64'(rvalid), 64'd0);
    chk("b2b_hold_rdata", rdata, 64'hA5A5_0000_0000_0002);

    // Byte mask, read immediately after the write
    access(1'b1, {2'd0, 11'd7}, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, "mask_wr0");
    access(1'b1, {2'd0, 11'd7}, 64'h1122_3344_5566_7788, 8'h0F, "mask_wr1");
    read_check({2'd0, 11'd7}, 64'hFFFF_FFFF_5566_7788, "mask_rd");

    // Bank 2 sleeps after exactly 16 idle cycles while bank 0 stays busy
    access(1'b1, {2'd2, 11'd9}, D2, 8'hFF, "b2_wr");
    en    = 1'b1;
    wmode = 1'b0;
    addr  = {2'd0, 11'd5};
    repeat (15) tick();
    chk("b2_sleep_c15", 64'(bank_sleep[2]), 64'd0);
    tick();
    chk("b2_sleep_c16", 64'(bank_sleep[2]), 64'd1);
    chk("b2_b0_ready", 64'(ready), 64'd1);
    // Held request to sleeping bank 2: three cycles of ready=0
    addr = {2'd2, 11'd9};
    #1;
    chk("wake_ready_s", 64'(ready), 64'd0);
    chk("wake_ls_drop", 64'(bank_sleep[2]), 64'd0);
    tick();
    chk("wake_ready_w1", 64'(ready), 64'd0);
    tick();
    chk("wake_ready_w2", 64'(ready), 64'd0);
    tick();
    chk("wake_ready_act", 64'(ready), 64'd1);
    tick();
    en = 1'b0;
    repeat (LAT - 1) tick();
    chk("wake_rvalid", 64'(rvalid), 64'd1);
    chk("wake_rdata", rdata, D2);

    // Bank 2 sleeps again; a bank 0 request during its wake is accepted
    en    = 1'b1;
    wmode = 1'b0;
    addr  = {2'd0, 11'd5};
    for (int i = 0; i < 40 && bank_sleep[2] !== 1'b1; i++) tick();
    chk("b2_sleep_again", 64'(bank_sleep[2]), 64'd1);
    addr = {2'd2, 11'd9};
    #1;
    chk("wake2_ready_s", 64'(ready), 64'd0);
    tick();
    addr = {2'd0, 11'd5};
    #1;
    chk("wake2_other_ready", 64'(ready), 64'd1);
    tick();
    addr = {2'd2, 11'd9};
    #1;
    chk("wake2_ready_w2", 64'(ready), 64'd0);
    tick();
    chk("wake2_ready_act", 64'(ready), 64'd1);
    tick();
    en = 1'b0;
    repeat (LAT - 1) tick();
    chk("wake2_rvalid", 64'(rvalid), 64'd1);
    chk("wake2_rdata", rdata, D2);

    // Bank 1 accessed on idle cycle 16: no sleep, counter restarts
    access(1'b1, {2'd1, 11'd3}, V1, 8'hFF, "b1_wr");
    repeat (15) tick();
    en    = 1'b1;
    wmode = 1'b0;
    addr  = {2'd1, 11'd3};
    #1;
    chk("b1_c16_ready", 64'(ready), 64'd1);
    tick();
    en = 1'b0;
    chk("b1_nosleep", 64'(bank_sleep[1]), 64'd0);
    repeat (LAT - 1) tick();
    chk("b1_rvalid", 64'(rvalid), 64'd1);
    chk("b1_rdata", rdata, V1);
    repeat (15 - (LAT - 1)) tick();
    chk("b1_restart_c15", 64'(bank_sleep[1]), 64'd0);
    tick();
    chk("b1_restart_c16", 64'(bank_sleep[1]), 64'd1);
    chk("all_asleep", 64'(bank_sleep), 64'hF);

    // Reset with a read in flight
    access(1'b0, {2'd1, 11'd3}, 64'd0, 8'd0, "rst_rd");
    rst_n = 1'b0;
    #1;
    chk("midrst_rvalid", 64'(rvalid), 64'd0);
    chk("midrst_rdata", rdata, 64'd0);
    chk("midrst_sleep", 64'(bank_sleep), 64'd0);
    chk("midrst_ready", 64'(ready), 64'd1);
    tick();
    chk("midrst_rvalid2", 64'(rvalid), 64'd0);
    tick();
    chk("midrst_rvalid3", 64'(rvalid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("postrst_rvalid", 64'(rvalid), 64'd0);
    chk("postrst_sleep", 64'(bank_sleep), 64'd0);
    chk("postrst_ready", 64'(ready), 64'd1);
    access(1'b1, {2'd3, 11'd0}, V3, 8'hFF, "postrst_wr");
    read_check({2'd3, 11'd0}, V3, "postrst_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cc_banks_param

`default_nettype wire
